// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the iterative multiplier.
// Ports: none (package only).
// Imported by seq_multiplier and by anything that needs its cycle count.
package mul_pkg;

  localparam int MUL_WIDTH  = 32;
  // Start edge to done cycle: 32 CALC + 1 SIGN + 1 DONE.
  localparam int MUL_CYCLES = 34;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } mul_state_t;

endpackage : mul_pkg

// File: rtl/seq_multiplier.sv
// Iterative shift-add MULT/MULTU: one multiplier bit per cycle, sign fix-up at the end.
// Latency: done (hi/lo valid) in the 34th cycle after start is sampled; repeat every 35.
// Backpressure: start is only sampled in IDLE; start while busy is dropped.
// Ports: clk, rst (sync, active-high), start, is_signed, A, B -> busy, done, hi, lo.
// hi/lo are registers that change only on the SIGN->DONE edge, so the downstream
// write-back mux sees a stable input for the whole time between operations.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand magnitude
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier magnitude; becomes the product low half
  logic [WIDTH-1:0] acc_q, acc_d;       // product upper half
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] result;

  // Signed operands are reduced to magnitudes so the datapath stays unsigned.
  // The most negative value negates to itself, which read as unsigned is the
  // correct magnitude, so no special case is needed.
  assign mag_a = (is_signed && A[WIDTH-1]) ? -A : A;
  assign mag_b = (is_signed && B[WIDTH-1]) ? -B : B;

  // Carry out of the upper-half add is kept as bit WIDTH and shifted back in.
  assign sum    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod   = {acc_q, mplier_q};
  assign result = neg_q ? -prod : prod;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        // Right shift of {carry, acc, multiplier}: consumed multiplier bits
        // fall off the bottom while product bits enter from the top.
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        hi_d    = result[2*WIDTH-1:WIDTH];
        lo_d    = result[WIDTH-1:0];
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Pure decodes of the state register, so no input reaches an output
  // without passing through a flop.
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier with a cycle-countdown reference model.
// Latency checked: done in cycle 34 after the start edge, busy low in cycle 35.
// Backpressure checked: start while busy is ignored; start held high repeats every 35.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a_op;
  logic [31:0] b_op;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .A         (a_op),
    .B         (b_op),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Reference model: an operation is a 34-cycle busy window whose last cycle
  // is done; the result becomes visible in that last cycle and then holds.
  int          m_rem = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem <= 0;
      m_res <= '0;
    end else if (m_rem == 0) begin
      if (start) begin
        m_rem  <= 34;
        m_pend <= ref_prod(is_signed, a_op, b_op);
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, (m_rem != 0)});
      chk("done", {63'd0, done}, {63'd0, (m_rem == 1)});
      chk("hi",   {32'd0, hi},   {32'd0, m_res[63:32]});
      chk("lo",   {32'd0, lo},   {32'd0, m_res[31:0]});
    end
  end

  // One operation. Optionally pulses a second start at cycle 10 (must be
  // ignored) and checks that the previous result is still held at cycle 33.
  task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit pulse10, input logic [31:0] prev_hi, input logic [31:0] prev_lo);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; is_signed = sgn; a_op = x; b_op = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (pulse10 && k == 10) begin start = 1'b1; a_op = 32'd9; b_op = 32'd9; end
      if (pulse10 && k == 11) start = 1'b0;
      if (pulse10 && k == 33) begin
        chk("held_hi_c33", {32'd0, hi}, {32'd0, prev_hi});
        chk("held_lo_c33", {32'd0, lo}, {32'd0, prev_lo});
      end
      if (done) begin cyc = k; break; end
    end
    chk("done_cycle", 64'(cyc), 64'd34);
    chk("res_hi", {32'd0, hi}, {32'd0, exp_hi});
    chk("res_lo", {32'd0, lo}, {32'd0, exp_lo});
    @(negedge clk);
    chk("busy_c35", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int done_seen;
    int dcyc [3];
    int nd;
    logic [31:0] eh [3];
    logic [31:0] el [3];

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a_op = '0; b_op = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi",   {32'd0, hi},   64'd0);
    chk("rst_lo",   {32'd0, lo},   64'd0);
    rst = 1'b0;

    // Pin the model with hand-computed values.
    chk("model_ff", ref_prod(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("model_m3x5", ref_prod(1'b1, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("model_min", ref_prod(1'b1, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, '0, '0);
    run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, '0, '0);
    run_op(1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, '0, '0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, '0, '0);
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, '0, '0);
    // Second request at cycle 10 must be dropped; prior result held until cycle 34.
    run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'h0000_002A, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);

    // Reset in CALC cycle 10 aborts the operation without a done.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; a_op = 32'd123; b_op = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi",   {32'd0, hi},   64'd0);
    chk("abort_lo",   {32'd0, lo},   64'd0);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'h0000_002A, 1'b0, '0, '0);

    // start held high: back-to-back operations 35 cycles apart.
    eh[0] = 32'd0; el[0] = 32'd6;
    eh[1] = 32'd0; el[1] = 32'd0;
    eh[2] = 32'd1; el[2] = 32'd0;
    nd = 0;
    dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; a_op = 32'd2; b_op = 32'd3;
    @(posedge clk);
    for (int k = 1; k <= 130 && nd < 3; k++) begin
      @(negedge clk);
      if (done) begin
        dcyc[nd] = k;
        chk("held_hi", {32'd0, hi}, {32'd0, eh[nd]});
        chk("held_lo", {32'd0, lo}, {32'd0, el[nd]});
        nd++;
        if (nd == 1) begin a_op = 32'd0; b_op = 32'h1234_5678; end
        if (nd == 2) begin a_op = 32'h0001_0000; b_op = 32'h0001_0000; end
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_done1", 64'(dcyc[0]), 64'd34);
    chk("held_done2", 64'(dcyc[1]), 64'd69);
    chk("held_done3", 64'(dcyc[2]), 64'd104);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier for the multi-cycle CPU datapath, executing MULT/MULTU in 34 cycles with a start/busy/done handshake. It sits directly upstream of the 32-bit 2:1 write-back select mux. Its registered `lo` (or `hi`) output is one mux input, and the control FSM selects it when the result is written back. Results are held stable between operations, so the mux input never glitches during multi-cycle control sequencing.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The product is `2*WIDTH`. Only 32 is verified.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement MULT, 0 = MULTU. Captured with `start`.
- `A`  in  WIDTH  multiplicand. Captured with `start`.
- `B`  in  WIDTH  multiplier. Captured with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from that cycle onward.
- `hi`  out  WIDTH  upper half of the product.
- `lo`  out  WIDTH  lower half of the product.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- **IDLE**
  - If `start` is high: capture the magnitudes of `A` and `B`.
    - Unsigned mode: magnitudes are the raw values.
    - Signed mode: magnitude is the value negated if its MSB is set.
  - Capture the negate flag = `is_signed & (A[31] ^ B[31])`.
  - Clear the 64-bit accumulator and the 5-bit counter, then go to CALC.
- **CALC**, 32 cycles:
  - If multiplier bit 0 = 1, add the multiplicand to the accumulator upper half (33-bit sum, carry kept).
  - Shift {carry, acc, multiplier} right by 1.
  - Increment the counter. When counter = 31, go to SIGN.
- **SIGN**, 1 cycle:
  - If the negate flag is set, take the 64-bit two's complement of the product.
  - Load `hi`/`lo` from the result, then go to DONE.
- **DONE**, 1 cycle: `done` = 1, then go to IDLE.
- Magnitude of 0x80000000 is 0x80000000 and is treated as unsigned 32-bit. No overflow is possible because the product fits 64 bits.
- `start` while `busy` is ignored. It has no effect on captured operands or on `hi`/`lo`.
- `hi`/`lo` change only on the SIGN→DONE edge. Otherwise they hold the last result.
- `rst` at any time, including mid-CALC:
  - state → IDLE;
  - `busy`, `done` = 0;
  - `hi`, `lo` = 0;
  - accumulator and counter cleared;
  - the aborted operation never produces `done`.
- Reset values: `busy` 0, `done` 0, `hi` 0x00000000, `lo` 0x00000000.

## Timing
- `start` sampled high at edge E0. Cycles are numbered after E0:
  - cycles 1–32: CALC;
  - cycle 33: SIGN;
  - cycle 34: DONE, with `done` = 1 and `hi`/`lo` new.
  - Cycle 35 is IDLE.
- `busy` is high in cycles 1–34 and low in cycle 35.
- Minimum repeat interval is 35 cycles. With `start` held high, the next operation is captured at the end of cycle 35.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `rst` takes priority over `start` in the same cycle.

## Structure
- Shared package `mul_pkg`:
  - state encoding localparams `S_IDLE`=2'd0, `S_CALC`=2'd1, `S_SIGN`=2'd2, `S_DONE`=2'd3;
  - `MUL_WIDTH`=32;
  - `MUL_CYCLES`=34.
- Single module, no sub-module. Operand absolute value and 64-bit negation are inline expressions.
- The control FSM consumes `busy`/`done` to stall its MULT state, and routes `hi`/`lo` to the HI/LO registers and the write-back mux.

## Test plan
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> `done` at cycle 34, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` low at cycle 35.
- Signed 0xFFFFFFFD (−3) × 0x00000005 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Same operands unsigned -> `hi`=0x00000004, `lo`=0xFFFFFFF1.
- Signed 0x80000000 × 0x80000000 -> `hi`=0x40000000, `lo`=0x00000000. Signed 0x80000000 × 0x00000001 -> `hi`=0xFFFFFFFF, `lo`=0x80000000.
- Start 7 × 6, then pulse `start` with 9 × 9 at cycle 10 -> second request ignored, `hi`=0, `lo`=0x0000002A. `hi`/`lo` keep the prior result until cycle 34.
- Assert `rst` in CALC cycle 10 -> next cycle `busy`=0, `hi`/`lo`=0, no `done` ever. Then 7 × 6 -> `lo`=0x2A after 34 cycles.
- `start` held high for 3 operations, 2 × 3 then 0 × 0x12345678 -> `done` pulses 35 cycles apart. `lo`=6, then `lo`=0 and `hi`=0.
